register_dump_unit: RTL and testbench

//  Debug-side reader of the decode-stage register bank. On command it walks the bank

---
 rtl/register_dump_unit.sv | 106 ++++++++++
 tb/tb_register_dump_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/register_dump_unit.sv
// Debug reader: walks the register bank via port A and streams each word
// to the UART transmitter, MSB byte first, holding the pipeline while busy.
module register_dump_unit #(
  parameter int NB_REG     = 5,
  parameter int NB_DATA    = 32,
  parameter int N_REGISTER = 32,
  parameter int NB_BYTE    = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  output logic [NB_REG-1:0]  o_addr_ra,
  input  logic [NB_DATA-1:0] i_data_ra,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_done
);

  localparam int NBYTES  = NB_DATA / NB_BYTE;
  localparam int NB_BIDX = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [NB_BIDX-1:0] LAST_BYTE = NB_BIDX'(NBYTES - 1);
  localparam logic [NB_REG-1:0]  LAST_REG  = NB_REG'(N_REGISTER - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET_ADDR,
    S_CAPTURE,
    S_SEND,
    S_WAIT_TX,
    S_NEXT,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [NB_REG-1:0]    reg_idx_q, reg_idx_d;
  logic [NB_BIDX-1:0]   byte_idx_q, byte_idx_d;
  logic [NB_DATA-1:0]   shift_q, shift_d;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      reg_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      reg_idx_q  <= reg_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    reg_idx_d  = reg_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d   = S_SET_ADDR;
          reg_idx_d = '0;
        end
      end
      S_SET_ADDR: state_d = S_CAPTURE;
      S_CAPTURE: begin
        shift_d    = i_data_ra;
        byte_idx_d = '0;
        state_d    = S_SEND;
      end
      S_SEND: state_d = S_WAIT_TX;
      // Done pulses are only honoured here, so stray ones elsewhere are dropped.
      S_WAIT_TX: begin
        if (i_tx_done) begin
          shift_d = shift_q << NB_BYTE;
          if (byte_idx_q == LAST_BYTE) begin
            state_d = S_NEXT;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = S_SEND;
          end
        end
      end
      S_NEXT: begin
        if (reg_idx_q == LAST_REG) begin
          state_d = S_DONE;
        end else begin
          reg_idx_d = reg_idx_q + 1'b1;
          state_d   = S_SET_ADDR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign o_addr_ra  = reg_idx_q;
  assign o_tx_data  = shift_q[NB_DATA-1 -: NB_BYTE];
  assign o_tx_start = (state_q == S_SEND);
  assign o_busy     = (state_q != S_IDLE);
  assign o_done     = (state_q == S_DONE);

endmodule

// File: tb/tb_register_dump_unit.sv
// Directed bench for register_dump_unit: bank model, UART tx responder,
// byte stream, handshake, latency, reset and start-while-busy checks.
module tb_register_dump_unit;

  logic        clk;
  logic        i_reset;
  logic        i_start;
  logic [4:0]  o_addr_ra;
  logic [31:0] i_data_ra;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_tx_done;
  logic        o_busy;
  logic        o_done;

  int checks = 0;
  int errors = 0;
  int nstrobe;
  int ndone;
  int quiet_strobes;
  logic [31:0] bank [32];
  logic [7:0]  got  [128];

  register_dump_unit dut (
    .i_clock   (clk),
    .i_reset   (i_reset),
    .i_start   (i_start),
    .o_addr_ra (o_addr_ra),
    .i_data_ra (i_data_ra),
    .o_tx_data (o_tx_data),
    .o_tx_start(o_tx_start),
    .i_tx_done (i_tx_done),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered bank read: data valid one clock after the address.
  always @(posedge clk) i_data_ra <= bank[o_addr_ra];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int n);
    logic [31:0] w;
    w = 32'hA500_0000 | 32'(n / 4);
    return 8'(w >> (8 * (3 - (n % 4))));
  endfunction

  task automatic start_dump();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("lat_busy_c1", 32'(o_busy), 1);
    chk("lat_addr_c1", 32'(o_addr_ra), 0);
    @(negedge clk);
    chk("lat_strobe_c2", 32'(o_tx_start), 0);
    @(negedge clk);
    chk("lat_strobe_c3", 32'(o_tx_start), 1);
  endtask

  // Tx responder; entered in the cycle of the first strobe.
  task automatic run_dump(input int dmode, input int stop_after,
                          input bit glitch, input bit start_busy,
                          input bit hold_start);
    int wait_ctr, gl_ctr, last_done, post, npulse;
    logic [7:0] held;
    nstrobe = 0; ndone = 0; npulse = 0;
    wait_ctr = 0; gl_ctr = 0; last_done = 0; post = -1;
    held = '0;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      i_tx_done = 1'b0;
      i_start   = 1'b0;
      if (wait_ctr > 0) begin
        wait_ctr--;
        chk("tx_data_hold", 32'(o_tx_data), 32'(held));
        chk("strobe_in_wait", 32'(o_tx_start), 0);
        if (wait_ctr == 0) begin
          i_tx_done = 1'b1;
          npulse++;
          last_done = cyc;
          if (glitch && (npulse % 4 == 0)) gl_ctr = 3;
          if (npulse == stop_after) return;
        end
      end else if (o_tx_start) begin
        chk("byte", 32'(o_tx_data), 32'(exp_byte(nstrobe)));
        if (nstrobe < 128) got[nstrobe] = o_tx_data;
        held = o_tx_data;
        nstrobe++;
        wait_ctr = (dmode == 0) ? 5 : int'($urandom_range(1, 20));
        if (glitch) i_tx_done = 1'b1;
        if (start_busy && (nstrobe == 10 || nstrobe == 100)) i_start = 1'b1;
      end else if (gl_ctr > 0) begin
        gl_ctr--;
        if (gl_ctr == 0) i_tx_done = 1'b1;
      end
      if (o_done) begin
        ndone++;
        chk("done_latency", 32'(cyc - last_done), 2);
        if (hold_start) begin
          i_start = 1'b1;
          return;
        end
        post = 3;
      end else if (post > 0) begin
        post--;
        if (post == 2) chk("busy_after_done", 32'(o_busy), 0);
        if (post == 0) return;
      end
      @(negedge clk);
    end
    checks++;
    errors++;
    $error("FAIL dump_timeout observed=%0d bytes expected=128", nstrobe);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) bank[k] = 32'hA500_0000 | 32'(k);
    i_reset = 1'b1; i_start = 1'b0; i_tx_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_strobe", 32'(o_tx_start), 0);
    chk("rst_tx_data", 32'(o_tx_data), 0);
    chk("rst_addr", 32'(o_addr_ra), 0);
    i_reset = 1'b0;

    // Stray done while idle
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
    chk("idle_done_busy", 32'(o_busy), 0);
    chk("idle_done_strobe", 32'(o_tx_start), 0);
    @(negedge clk);

    // Fixed 5-clock tx latency
    start_dump();
    run_dump(0, 0, 1'b0, 1'b0, 1'b0);
    chk("t1_bytes", 32'(nstrobe), 128);
    chk("t1_done", 32'(ndone), 1);
    chk("t1_r0_b0", 32'(got[0]), 32'hA5);
    chk("t1_r0_b3", 32'(got[3]), 32'h00);
    chk("t1_r31_b0", 32'(got[124]), 32'hA5);
    chk("t1_r31_b3", 32'(got[127]), 32'h1F);

    // Random tx latency
    start_dump();
    run_dump(1, 0, 1'b0, 1'b0, 1'b0);
    chk("t2_bytes", 32'(nstrobe), 128);
    chk("t2_done", 32'(ndone), 1);

    // Start pulses while busy
    start_dump();
    run_dump(1, 0, 1'b0, 1'b1, 1'b0);
    chk("t3_bytes", 32'(nstrobe), 128);
    chk("t3_done", 32'(ndone), 1);

    // Stray done in SEND, CAPTURE and IDLE
    start_dump();
    run_dump(0, 0, 1'b1, 1'b0, 1'b0);
    chk("t5_bytes", 32'(nstrobe), 128);
    chk("t5_done", 32'(ndone), 1);
    chk("t5_r31_b3", 32'(got[127]), 32'h1F);

    // Reset mid-dump after the 37th done
    start_dump();
    run_dump(0, 37, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    i_tx_done = 1'b0;
    i_reset   = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    chk("t4_busy", 32'(o_busy), 0);
    chk("t4_done", 32'(o_done), 0);
    chk("t4_strobe", 32'(o_tx_start), 0);
    chk("t4_tx_data", 32'(o_tx_data), 0);
    chk("t4_addr", 32'(o_addr_ra), 0);
    quiet_strobes = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_tx_start || o_busy) quiet_strobes++;
    end
    chk("t4_quiet", 32'(quiet_strobes), 0);
    start_dump();
    run_dump(0, 0, 1'b0, 1'b0, 1'b1);
    chk("t4_bytes", 32'(nstrobe), 128);
    chk("t4_first", 32'(got[0]), 32'hA5);
    chk("t4_done", 32'(ndone), 1);

    // Start held high across DONE restarts from the IDLE cycle
    @(negedge clk);
    chk("hold_idle_busy", 32'(o_busy), 0);
    start_dump();
    run_dump(0, 0, 1'b0, 1'b0, 1'b0);
    chk("hold_bytes", 32'(nstrobe), 128);
    chk("hold_done", 32'(ndone), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
